// File: rtl/penguen_koloni_pkg.sv
// Shared types and widths for the penguin colony scheduler: FSM encoding,
// counter/fish widths and a saturating increment helper.
package penguen_koloni_pkg;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        AVLA  = 2'd1,
        GECIS = 2'd2
    } durum_t;

    localparam int SAYAC_W  = 7;
    localparam int BALIK_W  = 3;
    localparam int ID_W     = 2;
    localparam int TOPLAM_W = 8;

    function automatic logic [SAYAC_W-1:0] doygun_artir(input logic [SAYAC_W-1:0] d);
        return (&d) ? d : d + SAYAC_W'(1);
    endfunction

endpackage

// File: rtl/penguen_koloni_rr_secici.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping around.
module rr_secici
    import penguen_koloni_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    uygun,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    secim,
    output logic [ID_W-1:0] secim_id,
    output logic            gecerli
);

    int j;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value held, which would otherwise infer a latch.
        secim    = '0;
        secim_id = '0;
        gecerli  = 1'b0;
        j        = 0;
        // Walk backwards so the candidate closest to ptr is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (uygun[j]) begin
                secim    = '0;
                secim[j] = 1'b1;
                secim_id = ID_W'(j);
                gecerli  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/penguen_koloni.sv
// Colony-level scheduler sharing one fishing hole among N_PENGUEN penguins.
// Define PENGUEN_ACLIK_EN to make waiting penguins lose a fish every 8 cycles.
module penguen_koloni
    import penguen_koloni_pkg::*;
#(
    parameter int N_PENGUEN = 4,
    parameter int HEDEF     = 20,
    parameter int DILIM     = 4
) (
    input  logic                           saat,
    input  logic                           reset,
    input  logic [N_PENGUEN-1:0]           istek,
    input  logic [BALIK_W-1:0]             avlanan_balik,
    output logic [N_PENGUEN-1:0]           izin,
    output logic [ID_W-1:0]                aktif_id,
    output logic [N_PENGUEN-1:0]           bitti_vektor,
    output logic [N_PENGUEN*SAYAC_W-1:0]   bitme_sureleri,
    output logic                           hepsi_bitti,
    output logic [SAYAC_W-1:0]             sayac
);

    durum_t              durum, durum_n;
    logic [ID_W-1:0]     ptr, ptr_sonraki;
    logic [7:0]          dilim, yeni_dilim;
    logic [TOPLAM_W-1:0] toplam [N_PENGUEN];
    logic [SAYAC_W-1:0]  bitme_sure [N_PENGUEN];

    logic [N_PENGUEN-1:0] uygun, secim, izin_n;
    logic [ID_W-1:0]      secim_id, aktif_id_n;
    logic                 gecerli, aktif_istek, bitiyor, birakiyor;
    logic [TOPLAM_W-1:0]  yeni_toplam;
    logic [SAYAC_W-1:0]   sayac_n;

    assign uygun       = istek & ~bitti_vektor;
    assign sayac_n     = doygun_artir(sayac);
    assign hepsi_bitti = &bitti_vektor;

    rr_secici #(.N(N_PENGUEN)) u_secici (
        .uygun    (uygun),
        .ptr      (ptr),
        .secim    (secim),
        .secim_id (secim_id),
        .gecerli  (gecerli)
    );

    // Outcome of the current counting edge for the granted penguin.
    always_comb begin
        aktif_istek = istek[aktif_id];
        yeni_toplam = toplam[aktif_id] + TOPLAM_W'(avlanan_balik);
        yeni_dilim  = dilim + 8'd1;
        bitiyor     = (durum == AVLA) && aktif_istek && (yeni_toplam >= TOPLAM_W'(HEDEF));
        birakiyor   = (durum == AVLA) &&
                      (!aktif_istek || bitiyor || (yeni_dilim == 8'(DILIM)));
        ptr_sonraki = (int'(aktif_id) == N_PENGUEN - 1) ? '0 : aktif_id + ID_W'(1);
    end

    always_ff @(posedge saat or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) durum <= BOS;
        else       durum <= durum_n;
    end

    always_comb begin
        durum_n = durum;
        case (durum)
            BOS, GECIS: durum_n = gecerli ? AVLA : BOS;
            AVLA:       durum_n = birakiyor ? GECIS : AVLA;
            default:    durum_n = BOS;
        endcase
    end

    always_comb begin
        izin_n     = '0;
        aktif_id_n = '0;
        case (durum)
            BOS, GECIS: begin
                if (gecerli) begin
                    izin_n     = secim;
                    aktif_id_n = secim_id;
                end
            end
            AVLA: begin
                if (!birakiyor) begin
                    izin_n     = izin;
                    aktif_id_n = aktif_id;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            sayac        <= '0;
            izin         <= '0;
            aktif_id     <= '0;
            ptr          <= '0;
            dilim        <= '0;
            bitti_vektor <= '0;
            // NOTE: the per-penguin arrays are small register files that must
            // read as zero straight after reset, so each entry is cleared here.
            for (int i = 0; i < N_PENGUEN; i++) begin
                toplam[i]     <= '0;
                bitme_sure[i] <= '0;
            end
        end else begin
            sayac    <= sayac_n;
            izin     <= izin_n;
            aktif_id <= aktif_id_n;
            dilim    <= (durum == AVLA) ? yeni_dilim : 8'd0;
            if (birakiyor) ptr <= ptr_sonraki;
            for (int i = 0; i < N_PENGUEN; i++) begin
                if (durum == AVLA && izin[i] && istek[i]) begin
                    toplam[i] <= yeni_toplam;
                    if (bitiyor) begin
                        bitti_vektor[i] <= 1'b1;
                        bitme_sure[i]   <= sayac_n;
                    end
                end
`ifdef PENGUEN_ACLIK_EN
                else if (sayac[2:0] == 3'd7 && !bitti_vektor[i] && !izin[i] &&
                         toplam[i] != '0) begin
                    toplam[i] <= toplam[i] - TOPLAM_W'(1);
                end
`endif
            end
        end
    end

    for (genvar g = 0; g < N_PENGUEN; g++) begin : g_paket
        assign bitme_sureleri[g*SAYAC_W +: SAYAC_W] = bitme_sure[g];
    end

endmodule

// File: tb/tb_penguen_koloni.sv
// Scoreboard bench for penguen_koloni: a behavioural colony model predicts each
// cycle's outputs; a monitor compares them after every rising edge.
module tb_penguen_koloni;

    localparam int N     = 4;
    localparam int HEDEF = 20;
    localparam int DILIM = 4;

    logic        saat = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  istek = '0;
    logic [2:0]  avlanan_balik = '0;
    logic [3:0]  izin;
    logic [1:0]  aktif_id;
    logic [3:0]  bitti_vektor;
    logic [27:0] bitme_sureleri;
    logic        hepsi_bitti;
    logic [6:0]  sayac;

    penguen_koloni #(.N_PENGUEN(N), .HEDEF(HEDEF), .DILIM(DILIM)) dut (
        .saat           (saat),
        .reset          (reset),
        .istek          (istek),
        .avlanan_balik  (avlanan_balik),
        .izin           (izin),
        .aktif_id       (aktif_id),
        .bitti_vektor   (bitti_vektor),
        .bitme_sureleri (bitme_sureleri),
        .hepsi_bitti    (hepsi_bitti),
        .sayac          (sayac)
    );

    always #5 saat = ~saat;

    typedef struct {
        logic [3:0]  izin;
        logic [1:0]  id;
        logic [3:0]  bitti;
        logic [27:0] bitme;
        logic        hepsi;
        logic [6:0]  sayac;
    } beklenen_t;

    beklenen_t kuyruk[$];
    int hata   = 0;
    int toplam = 0;

    // Behavioural colony: who holds the hole, fish totals, finish times.
    int m_sayac, m_ptr, m_grant, m_slice;
    int m_tot[N];
    bit m_done[N];
    int m_fin[N];

    task automatic check(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        toplam++;
        if (gercek !== beklenen) begin
            hata++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", ad, gercek, beklenen, $time);
        end
    endtask

    task automatic model_sifirla();
        m_sayac = 0; m_ptr = 0; m_grant = -1; m_slice = 0;
        for (int i = 0; i < N; i++) begin
            m_tot[i] = 0; m_done[i] = 1'b0; m_fin[i] = 0;
        end
    endtask

    task automatic model_adim(input logic [3:0] ist, input int fish);
        beklenen_t e;
        int yeni = (m_sayac < 127) ? m_sayac + 1 : 127;
        int g = m_grant;
`ifdef PENGUEN_ACLIK_EN
        if (m_sayac % 8 == 7)
            for (int i = 0; i < N; i++)
                if (!m_done[i] && i != g && m_tot[i] > 0) m_tot[i]--;
`endif
        if (g >= 0) begin
            if (!ist[g]) begin
                m_grant = -1;
                m_ptr   = (g + 1) % N;
            end else begin
                m_tot[g] += fish;
                m_slice++;
                if (m_tot[g] >= HEDEF) begin
                    m_done[g] = 1'b1;
                    m_fin[g]  = yeni;
                end
                if (m_done[g] || m_slice == DILIM) begin
                    m_grant = -1;
                    m_ptr   = (g + 1) % N;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (ist[c] && !m_done[c]) begin
                    m_grant = c;
                    m_slice = 0;
                    break;
                end
            end
        end
        m_sayac = yeni;

        e.izin  = (m_grant >= 0) ? 4'(1 << m_grant) : 4'd0;
        e.id    = (m_grant >= 0) ? 2'(m_grant) : 2'd0;
        e.bitme = '0;
        for (int i = 0; i < N; i++) begin
            e.bitti[i]        = m_done[i];
            e.bitme[7*i +: 7] = 7'(m_fin[i]);
        end
        e.hepsi = &e.bitti;
        e.sayac = 7'(m_sayac);
        kuyruk.push_back(e);
    endtask

    always @(posedge saat) begin
        beklenen_t e;
        #1;
        if (kuyruk.size() > 0) begin
            e = kuyruk.pop_front();
            check("izin",           64'(izin),           64'(e.izin));
            check("aktif_id",       64'(aktif_id),       64'(e.id));
            check("bitti_vektor",   64'(bitti_vektor),   64'(e.bitti));
            check("bitme_sureleri", 64'(bitme_sureleri), 64'(e.bitme));
            check("hepsi_bitti",    64'(hepsi_bitti),    64'(e.hepsi));
            check("sayac",          64'(sayac),          64'(e.sayac));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_sifirla();
        kuyruk.delete();
        @(posedge saat);
        #2;
        reset = 1'b0;
    endtask

    task automatic tick(input logic [3:0] ist, input logic [2:0] fish);
        @(negedge saat);
        istek         = ist;
        avlanan_balik = fish;
        model_adim(ist, int'(fish));
        @(posedge saat);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] ist;
        do_reset();
        check("reset_sayac", 64'(sayac), 64'd0);
        check("reset_izin",  64'(izin),  64'd0);

        // Single requester
        for (int c = 0; c < 8; c++) tick(4'b0001, 3'd5);
        check("tek_bitme0", 64'(bitme_sureleri[6:0]), 64'd5);
        check("tek_izin_son", 64'(izin), 64'd0);

        // Full colony
        do_reset();
        for (int c = 0; c < 18; c++) tick(4'b1111, 3'd7);
        check("koloni_bitme", 64'(bitme_sureleri), 64'({7'd16, 7'd12, 7'd8, 7'd4}));
        check("koloni_hepsi", 64'(hepsi_bitti), 64'd1);

        // Time-slice alternation (with hunger active when the macro is on)
        do_reset();
        for (int c = 0; c < 100; c++) tick(4'b0011, 3'd1);
        check("dilim_bitti", 64'(bitti_vektor), 64'b0011);

        // Request drop mid-grant
        do_reset();
        tick(4'b0011, 3'd3);
        tick(4'b0011, 3'd3);
        tick(4'b0010, 3'd3);
        check("dusme_izin0", 64'(izin), 64'd0);
        tick(4'b0010, 3'd3);
        check("dusme_izin1", 64'(izin), 64'b0010);
        for (int c = 0; c < 12; c++) tick(4'b0011, 3'd3);

        // Reset mid-grant, then single requester again
        do_reset();
        for (int c = 0; c < 3; c++) tick(4'b0001, 3'd5);
        #1;
        reset = 1'b1;
        #1;
        check("ara_reset_izin",  64'(izin),           64'd0);
        check("ara_reset_id",    64'(aktif_id),       64'd0);
        check("ara_reset_bitti", 64'(bitti_vektor),   64'd0);
        check("ara_reset_bitme", 64'(bitme_sureleri), 64'd0);
        check("ara_reset_hepsi", 64'(hepsi_bitti),    64'd0);
        check("ara_reset_sayac", 64'(sayac),          64'd0);
        do_reset();
        for (int c = 0; c < 8; c++) tick(4'b0001, 3'd5);
        check("ara_reset_bitme0", 64'(bitme_sureleri[6:0]), 64'd5);

        // Randomized episodes
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            ist = 4'($urandom_range(0, 15));
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 3) == 0) ist = 4'($urandom_range(0, 15));
                tick(ist, 3'($urandom_range(0, 7)));
            end
        end

        @(posedge saat);
        #3;
        check("kuyruk_bos", 64'(kuyruk.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", hata, toplam);
        $finish;
    end

endmodule

// File: doc/penguen_koloni.md
# penguen_koloni

Round-robin scheduler that shares one fishing hole among `N_PENGUEN` penguins. Each cycle, the single `avlanan_balik` fish stream is credited only to the penguin currently holding the grant. The block keeps a fish total per penguin, marks each penguin done when it reaches `HEDEF`, and latches the cycle at which that happened. It sits above the single-penguin counter as the colony-level controller and owns the shared resource and the global cycle count.

## Interface
- `N_PENGUEN`, default 4: number of requesters; width of the vectors.
- `HEDEF`, default 20: fish target per penguin.
- `DILIM`, default 4: maximum counted cycles per grant (time slice).
- `saat`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous reset, active-high.
- `istek`, input, `N_PENGUEN`: per-penguin request to fish.
- `avlanan_balik`, input, 3: fish caught at the shared hole this cycle (0–7).
- `izin`, output, `N_PENGUEN`: registered grant, one-hot or zero.
- `aktif_id`, output, 2: index of the granted penguin; 0 when `izin` is 0.
- `bitti_vektor`, output, `N_PENGUEN`: per-penguin done flags, sticky.
- `bitme_sureleri`, output, `N_PENGUEN*7`: packed finish times, penguin i at bits [7i+6:7i].
- `hepsi_bitti`, output, 1: all penguins done.
- `sayac`, output, 7: global cycle counter.

## Operation
- **Reset:** asynchronous. All outputs, totals, pointer, slice counter and FSM state go to 0 / BOS immediately.
- **`sayac`:** increments on every edge after reset. Saturates at 127.
- **Totals:** 8-bit per penguin. A penguin with its `bitti` flag set is masked out of arbitration.
- **FSM states:** BOS, AVLA, GECIS.
  - **BOS:** if any eligible request exists (`istek` & ~`bitti_vektor`), the search starts at pointer `ptr` and wraps. The first hit is granted: `izin` is loaded, the slice counter is cleared, and the state goes to AVLA. Otherwise the FSM stays in BOS.
  - **AVLA:** on each edge with `izin[i]` set, the total for penguin i grows by `avlanan_balik` and the slice counter increments. The grant ends when either of these is true:
    - the new total is ≥ `HEDEF`: set `bitti[i]`, latch `bitme_sure[i]` to the post-edge value of `sayac`;
    - the slice counter reaches `DILIM`.
    - When the grant ends, `izin` goes to 0, `ptr` goes to i+1 (mod N), and the state goes to GECIS.
  - **AVLA, request dropped:** if `istek[i]` is low at an edge, no fish is counted, `izin` goes to 0, `ptr` goes to i+1, and the state goes to GECIS. The total is retained.
  - **GECIS:** lasts one cycle; fish is ignored. It then behaves as BOS, granting the next eligible penguin at the next edge or returning to BOS.
- **Simultaneous finish and slice end:** treated as a finish; the finish time is latched.
- **Latched values:** a finish time is written exactly once. `bitti` stays set until reset.
- **`hepsi_bitti`:** the AND of `bitti_vektor`, registered with it.

## Timing
- A grant appears one edge after an eligible request is seen in BOS or GECIS.
- The first fish counted is the one present at the edge after `izin` rises.
- Done/finish time are visible right after the counting edge; there is no extra latency.
- Handover costs exactly one idle cycle (GECIS).
- Minimum grant is 1 counted cycle; maximum is `DILIM`.
- Reset asserted mid-grant clears everything without waiting for `saat`.

## Configuration
- **`PENGUEN_ACLIK_EN` defined:** on every edge where `sayac[2:0]`==7, each penguin that is not done, not granted and has a total above 0 loses 1 fish (hunger).
- **Not defined:** totals only ever increase.
- Neither mode changes arbitration.

## Structure
- **Shared package:** FSM state encoding (BOS / AVLA / GECIS), the `sayac` width (7) and the fish width (3).
- **Sub-module `rr_secici`:** combinational round-robin picker. Inputs are the eligibility mask and `ptr`; outputs are the one-hot choice, index and valid.

## Test plan
All scenarios use defaults, macro off unless stated.
- **Single requester:** reset, `istek`=0001, fish=5 held. Expect `izin`=0001 from `sayac`=1, `bitti_vektor`=0001, `bitme_sure[0]`=5, `izin`=0 afterwards.
- **Full colony:** `istek`=1111, fish=7. Expect grants in order 0,1,2,3 with one GECIS cycle between them, `bitme_sureleri`=4,8,12,16, and `hepsi_bitti`=1 at `sayac`=16.
- **Time-slice alternation:** `istek`=0011, fish=1. Expect `izin` to run 0001×4, 0, 0010×4, 0, repeating. Both penguins are done with totals of 20 after 5 slices each.
- **Request drop:** `istek`[0] falls mid-grant. Expect `izin`=0 next edge, total[0] unchanged, penguin 1 granted one edge later.
- **Reset mid-grant:** assert `reset` between edges. Expect all outputs 0 immediately; after release, behaviour is identical to the single-requester scenario.
- **Hunger (`PENGUEN_ACLIK_EN`):** `istek`=0011, fish=2. At `sayac`=7, the non-granted penguin's total drops by 1. The finish times are later than in the macro-off run.
